// File: rtl/output_streamer_if.sv
// ---------------------------------------------------------------------------
// output_streamer_if
//   Byte-stream (valid/ready) link between output_streamer and the external
//   I/O. A beat transfers on any rising clk edge where out_valid and
//   out_ready are both high.
//
//   out_data   beat payload                    (master -> slave)
//   out_valid  beat present                    (master -> slave)
//   out_last   final beat of the final word    (master -> slave)
//   out_ready  consumer accepts the beat       (slave  -> master)
// ---------------------------------------------------------------------------
interface output_streamer_if #(
    parameter int OUT_WIDTH = 8
) ();

    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/output_streamer.sv
// ---------------------------------------------------------------------------
// output_streamer
//   Drains a run of words from the output SRAM onto the byte stream. Each
//   DATA_WIDTH word is read with a single-cycle read and split into
//   BEATS = DATA_WIDTH/OUT_WIDTH beats, least-significant first. done pulses
//   for one cycle after the final beat is accepted.
//
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       job request, sampled only in IDLE
//   start_addr  first word address, sampled with start
//   count       words to send (clamped to DEPTH), sampled with start
//   abort       cancel the current job, wins over start and handshake
//   busy        high in every non-IDLE state
//   done        one-cycle pulse at normal completion
//   sram_re     SRAM read enable
//   sram_raddr  SRAM read address (addresses wrap modulo DEPTH)
//   sram_rdata  SRAM read data, valid the cycle after sram_re
//   out_if      byte stream (master side)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start
//   FETCH | sram_re high for the current address
//   LOAD  | sram_rdata valid, captured into the shift register
//   SEND  | beats offered on the stream, one per handshake
//   DONE  | done pulse, back to IDLE next cycle
// ---------------------------------------------------------------------------
module output_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_re,
    output logic [ADDR_WIDTH-1:0] sram_raddr,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output_streamer_if.master     out_if
);

    localparam int BEATS  = DATA_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0]     BEAT_LAST   = BEAT_W'(BEATS - 1);
    // Beat index whose handshake makes the final beat of a word the next one.
    localparam logic [BEAT_W-1:0]     BEAT_PENULT = BEAT_W'(BEATS - 2);
    localparam logic [ADDR_WIDTH:0]   DEPTH_WORDS = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_WORD    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   remaining;   // words left, including the one in flight
    logic [BEAT_W-1:0]     beat;
    logic [DATA_WIDTH-1:0] shreg;

    logic [ADDR_WIDTH:0]   count_clamped;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  last_word;
    logic                  handshake;

    assign count_clamped = (count > DEPTH_WORDS) ? DEPTH_WORDS : count;
    // Explicit wrap so a non-power-of-two DEPTH also works.
    assign addr_next     = (sram_raddr == ADDR_MAX) ? '0 : sram_raddr + 1'b1;
    assign last_word     = (remaining == ONE_WORD);
    assign handshake     = out_if.out_valid & out_if.out_ready;

    // The low bits of the shift register are the beat on offer; they only
    // change on a handshake or a load, which keeps out_data stable while
    // stalled.
    assign out_if.out_data = shreg[OUT_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            remaining        <= '0;
            beat             <= '0;
            shreg            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            sram_re          <= 1'b0;
            sram_raddr       <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_last  <= 1'b0;
        end else if (abort) begin
            // The in-flight beat is dropped; no done pulse for a cancelled job.
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            sram_re          <= 1'b0;
            shreg            <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            sram_raddr <= start_addr;
                            remaining  <= count_clamped;
                            sram_re    <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    sram_re <= 1'b0;
                    state   <= LOAD;
                end

                LOAD: begin
                    shreg            <= sram_rdata;
                    beat             <= '0;
                    out_if.out_valid <= 1'b1;
                    out_if.out_last  <= last_word && (BEATS == 1);
                    state            <= SEND;
                end

                SEND: begin
                    if (handshake) begin
                        shreg <= shreg >> OUT_WIDTH;
                        if (beat == BEAT_LAST) begin
                            out_if.out_valid <= 1'b0;
                            out_if.out_last  <= 1'b0;
                            if (last_word) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                remaining  <= remaining - ONE_WORD;
                                sram_raddr <= addr_next;
                                sram_re    <= 1'b1;
                                state      <= FETCH;
                            end
                        end else begin
                            beat            <= beat + 1'b1;
                            out_if.out_last <= last_word && (beat == BEAT_PENULT);
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state            <= IDLE;
                    busy             <= 1'b0;
                    done             <= 1'b0;
                    sram_re          <= 1'b0;
                    out_if.out_valid <= 1'b0;
                    out_if.out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_streamer.sv
module tb_output_streamer;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int OW    = 8;
    localparam int BEATS = DW / OW;
    localparam int MAXC  = 1024;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   count;
    logic          abort;
    logic          busy;
    logic          done;
    logic          sram_re;
    logic [AW-1:0] sram_raddr;
    logic [DW-1:0] sram_rdata;

    output_streamer_if #(.OUT_WIDTH(OW)) s_if ();

    output_streamer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .OUT_WIDTH (OW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_addr(start_addr),
        .count     (count),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .sram_re   (sram_re),
        .sram_raddr(sram_raddr),
        .sram_rdata(sram_rdata),
        .out_if    (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM with one-cycle registered read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (sram_re) sram_rdata <= mem[sram_raddr];

    int    total = 0;
    int    bad   = 0;
    string cur_job = "reset";

    // per-cycle expectations for one job, cycle 0 = start cycle
    bit rdy     [MAXC];
    bit e_re    [MAXC];
    bit e_valid [MAXC];
    bit e_last  [MAXC];
    bit e_done  [MAXC];
    bit e_busy  [MAXC];
    int e_raddr [MAXC];
    int e_data  [MAXC];
    int done_c;

    typedef struct {
        int addr;
        int cnt;
        int stall_lo;
        int stall_hi;
        int spur;
        int exp_done;
        int exp_reads;
        int exp_beats;
        int exp_lasts;
        int exp_first;
        int exp_final;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s cycle %0d: got 0x%0h want 0x%0h", cur_job, nm, c, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},       0, busy,             0);
        chk({tag, "_done"},       0, done,             0);
        chk({tag, "_sram_re"},    0, sram_re,          0);
        chk({tag, "_sram_raddr"}, 0, sram_raddr,       0);
        chk({tag, "_out_valid"},  0, s_if.out_valid,   0);
        chk({tag, "_out_data"},   0, s_if.out_data,    0);
        chk({tag, "_out_last"},   0, s_if.out_last,    0);
    endtask

    task automatic fill_rdy(input int lo, input int hi, input int pct);
        for (int c = 0; c < MAXC; c++)
            rdy[c] = (c >= lo && c <= hi) ? 1'b0 : ($urandom_range(0, 99) >= pct);
    endtask

    // Timeline model: each word is one read cycle, one load cycle, then each
    // beat is offered until the consumer is ready.
    task automatic build_model(input int a, input int cnt);
        int n;
        int t;
        int word;
        int bv;
        bit acc;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        for (int c = 0; c < MAXC; c++) begin
            e_re[c] = 0; e_valid[c] = 0; e_last[c] = 0; e_done[c] = 0; e_busy[c] = 0;
            e_raddr[c] = 0; e_data[c] = 0;
        end
        t = 1;
        for (int w = 0; w < n; w++) begin
            e_re[t]    = 1;
            e_raddr[t] = (a + w) % DEPTH;
            word       = int'(mem[(a + w) % DEPTH]);
            t += 2;
            for (int b = 0; b < BEATS; b++) begin
                bv = (word >> (b * OW)) & ((1 << OW) - 1);
                do begin
                    e_valid[t] = 1;
                    e_data[t]  = bv;
                    e_last[t]  = (w == n - 1) && (b == BEATS - 1);
                    acc        = rdy[t];
                    t++;
                end while (!acc && t < MAXC - 2);
            end
        end
        done_c = t;
        e_done[t] = 1;
        for (int c = 1; c <= t; c++) e_busy[c] = 1;
    endtask

    task automatic run_job(input int a, input int cnt, input int spur,
                           output int o_done, output int o_reads, output int o_beats,
                           output int o_lasts, output int o_first, output int o_final);
        bit hs;
        build_model(a, cnt);
        o_done = -1; o_reads = 0; o_beats = 0; o_lasts = 0; o_first = -1; o_final = -1;
        chk("idle_busy", 0, busy, 0);
        chk("idle_done", 0, done, 0);
        start      = 1'b1;
        start_addr = AW'(a);
        count      = (AW + 1)'(cnt);
        s_if.out_ready = rdy[0];
        tick();
        for (int c = 1; c <= done_c; c++) begin
            s_if.out_ready = rdy[c];
            if (c == spur) begin
                start      = 1'b1;
                start_addr = AW'($urandom_range(0, DEPTH - 1));
                count      = (AW + 1)'($urandom_range(1, 20));
            end else begin
                start = 1'b0;
            end
            chk("busy",      c, busy,           e_busy[c]);
            chk("done",      c, done,           e_done[c]);
            chk("sram_re",   c, sram_re,        e_re[c]);
            if (e_re[c]) chk("sram_raddr", c, sram_raddr, e_raddr[c]);
            chk("out_valid", c, s_if.out_valid, e_valid[c]);
            if (e_valid[c]) chk("out_data", c, s_if.out_data, e_data[c]);
            chk("out_last",  c, s_if.out_last,  e_last[c]);
            hs = s_if.out_valid && rdy[c];
            if (sram_re) o_reads++;
            if (hs) begin
                if (o_beats == 0) o_first = int'(s_if.out_data);
                o_final = int'(s_if.out_data);
                o_beats++;
                if (s_if.out_last) o_lasts++;
            end
            if (done && o_done < 0) o_done = c;
            tick();
        end
        start = 1'b0;
    endtask

    int od, orr, ob, ol, of, ofn;

    initial begin
        vecs[0] = '{0,  3, -1, -1, 0, 13,  3,  6, 1, 'h34, 'h00};
        vecs[1] = '{0,  3,  3,  5, 0, 16,  3,  6, 1, 'h34, 'h00};
        vecs[2] = '{14, 4, -1, -1, 7, 17,  4,  8, 1, 'h0E, 'hAB};
        vecs[3] = '{0, 20, -1, -1, 0, 65, 16, 32, 1, 'h34, 'hCF};
        vecs[4] = '{5,  0, -1, -1, 0,  1,  0,  0, 0,   -1,   -1};
        vecs[5] = '{15, 1, -1, -1, 0,  5,  1,  2, 1, 'h0F, 'hCF};

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'('hC000 | (i << 8) | i);
        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;
        mem[2] = 16'h00FF;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_addr = '0; count = '0;
        s_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk_zero("after_reset");

        for (int i = 0; i < 6; i++) begin
            cur_job = $sformatf("vec%0d", i);
            fill_rdy(vecs[i].stall_lo, vecs[i].stall_hi, 0);
            run_job(vecs[i].addr, vecs[i].cnt, vecs[i].spur, od, orr, ob, ol, of, ofn);
            chk("done_cycle", 0, od,  vecs[i].exp_done);
            chk("n_reads",    0, orr, vecs[i].exp_reads);
            chk("n_beats",    0, ob,  vecs[i].exp_beats);
            chk("n_last",     0, ol,  vecs[i].exp_lasts);
            chk("first_beat", 0, of,  vecs[i].exp_first);
            chk("final_beat", 0, ofn, vecs[i].exp_final);
        end

        // abort on the second beat of word 1
        cur_job = "abort";
        s_if.out_ready = 1'b1;
        start = 1'b1; start_addr = '0; count = 5'd3;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("pre_valid", 8, s_if.out_valid, 1);
        chk("pre_data",  8, s_if.out_data,  'hAB);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy",  9, busy,           0);
        chk("ab_valid", 9, s_if.out_valid, 0);
        chk("ab_re",    9, sram_re,        0);
        chk("ab_last",  9, s_if.out_last,  0);
        for (int c = 9; c < 13; c++) begin
            chk("ab_no_done", c, done, 0);
            tick();
        end
        cur_job = "after_abort";
        fill_rdy(-1, -1, 0);
        run_job(3, 1, 0, od, orr, ob, ol, of, ofn);
        chk("first_beat", 0, of,  'h03);
        chk("final_beat", 0, ofn, 'hC3);

        // reset asserted during LOAD
        cur_job = "reset_mid";
        s_if.out_ready = 1'b1;
        start = 1'b1; start_addr = 4'd2; count = 5'd2;
        tick();
        start = 1'b0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("async");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cur_job = "after_reset_mid";
        fill_rdy(-1, -1, 0);
        run_job(2, 1, 0, od, orr, ob, ol, of, ofn);
        chk("first_beat", 0, of,  'hFF);
        chk("final_beat", 0, ofn, 'h00);

        // randomized jobs against the timeline model
        for (int j = 0; j < 25; j++) begin
            int a, cnt, pct, spur, n;
            cur_job = $sformatf("rand%0d", j);
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            a    = $urandom_range(0, DEPTH - 1);
            cnt  = $urandom_range(0, 20);
            pct  = $urandom_range(0, 50);
            spur = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 20) : 0;
            n    = (cnt > DEPTH) ? DEPTH : cnt;
            fill_rdy(-1, -1, pct);
            run_job(a, cnt, spur, od, orr, ob, ol, of, ofn);
            chk("n_reads", 0, orr, n);
            chk("n_beats", 0, ob,  n * BEATS);
            chk("n_last",  0, ol,  (n > 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
